// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the sdram port arbiter.
//   addr_t / data_t / chan_t : default-width address, data and channel-id types
//   state_t                  : arbiter FSM states
//   rr_wrap                  : folds an index that ran past N back into the round-robin range
package sdram_port_arbiter_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 24;
    localparam int DW_DEF = 16;

    typedef logic [AW_DEF-1:0]         addr_t;
    typedef logic [DW_DEF-1:0]         data_t;
    typedef logic [$clog2(N_DEF)-1:0]  chan_t;

    typedef enum logic {IDLE, GRANT} state_t;

    // Round-robin channels occupy lo..n-1; an index of n or more wraps back to lo.
    function automatic int rr_wrap(input int idx, input int lo, input int n);
        return (idx >= n) ? idx - (n - lo) : idx;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO holding the channel id of each outstanding read.
//   clk, n_reset : clock, async active-low reset (empties the FIFO)
//   push, din    : enqueue din (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : oldest entry
//   full, empty  : decoded from the registered occupancy count
//   count        : occupancy, 0..D
module tag_fifo #(
    parameter int W = 2,
    parameter int D = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 push,
    input  logic [W-1:0]         din,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);
    localparam int PTRW = $clog2(D);
    localparam int CNTW = PTRW + 1;

    logic [W-1:0]    mem [D];
    logic [PTRW-1:0] wptr, rptr;
    logic            do_push, do_pop;

    assign full    = (count == CNTW'(D));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTRW'(1);
            if (do_pop)  rptr <= rptr + PTRW'(1);
            // Simultaneous push and pop leave the count untouched.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: N-channel arbiter and request mux in front of the sdram controller.
//   clk, n_reset          : clock, async active-low reset
//   req/we/addr/data [N]  : per-channel request, held stable until rdy
//   rdy [N]               : one-cycle accept pulse for the granted channel
//   rvalid [N], rdata     : read return steered to the issuing channel
//   if_req/we/addr/data   : request towards the controller
//   if_rdy                : controller accepted if_req
//   if_rvalid, if_rdata   : in-order read return from the controller
//   pending               : outstanding reads
//   err                   : sticky, read data arrived with no read outstanding
// Channels 0..PRIO_N-1 are fixed priority (lowest index wins) and beat the
// round-robin channels PRIO_N..N-1.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int AW     = 24,
    parameter int DW     = 16,
    parameter int PRIO_N = 1,
    parameter int TD     = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [N-1:0]             req,
    input  logic [N-1:0]             we,
    input  logic [N-1:0][AW-1:0]     addr,
    input  logic [N-1:0][DW-1:0]     data,
    output logic [N-1:0]             rdy,
    output logic [N-1:0]             rvalid,
    output logic [DW-1:0]            rdata,
    output logic                     if_req,
    output logic                     if_we,
    output logic [AW-1:0]            if_addr,
    output logic [DW-1:0]            if_data,
    input  logic                     if_rdy,
    input  logic                     if_rvalid,
    input  logic [DW-1:0]            if_rdata,
    output logic [$clog2(TD):0]      pending,
    output logic                     err
);
    localparam int CW = $clog2(N);
    localparam int PW = $clog2(N + 1);  // rr_ptr may hold N when PRIO_N == N

    state_t          state;
    logic [CW-1:0]   sel;
    logic [PW-1:0]   rr_ptr;
    logic [N-1:0]    elig;
    logic            win_vld, win_rr;
    logic [CW-1:0]   win;
    logic [PW-1:0]   rr_next;
    logic            fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]   head;

    // Reads are masked while every tag slot is taken; writes never need a tag.
    assign elig = req & (we | {N{~fifo_full}});

    // Round-robin search runs from the highest offset down so the closest
    // channel to rr_ptr is written last; the fixed-priority pass then overrides it.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_rr  = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = N - PRIO_N - 1; k >= 0; k--) begin
            idx = rr_wrap(int'(rr_ptr) + k, PRIO_N, N);
            if (elig[CW'(idx)]) begin
                win_vld = 1'b1;
                win_rr  = 1'b1;
                win     = CW'(idx);
            end
        end
        for (int i = PRIO_N - 1; i >= 0; i--) begin
            if (elig[CW'(i)]) begin
                win_vld = 1'b1;
                win_rr  = 1'b0;
                win     = CW'(i);
            end
        end
    end

    assign rr_next = PW'(rr_wrap(int'(win) + 1, PRIO_N, N));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= PW'(PRIO_N);
            if_req <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    sel    <= win;
                    state  <= GRANT;
                    if_req <= 1'b1;
                    if (win_rr) rr_ptr <= rr_next;
                end
                GRANT: if (if_rdy) begin
                    state  <= IDLE;
                    if_req <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    if_req <= 1'b0;
                end
            endcase
        end
    end

    // Request mux is forced to zero outside a grant so nothing leaks from channel 0.
    assign if_we   = if_req & we[sel];
    assign if_addr = if_req ? addr[sel] : '0;
    assign if_data = if_req ? data[sel] : '0;
    assign rdy     = (if_req && if_rdy) ? (N'(1) << sel) : '0;

    assign push    = if_req && if_rdy && !we[sel];
    assign pop     = if_rvalid && !fifo_empty;
    assign rvalid  = pop ? (N'(1) << head) : '0;
    assign rdata   = if_rdata;

    tag_fifo #(.W(CW), .D(TD)) u_tags (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .din     (sel),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (pending)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                      err <= 1'b0;
        else if (if_rvalid && fifo_empty)  err <= 1'b1;
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int N = 4, AW = 24, DW = 16, PRIO_N = 1, TD = 8, CW = 2;

    logic                  clk = 1'b0;
    logic                  n_reset;
    logic [N-1:0]          req, we;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0][DW-1:0]  data;
    logic [N-1:0]          rdy, rvalid;
    logic [DW-1:0]         rdata;
    logic                  if_req, if_we;
    logic [AW-1:0]         if_addr;
    logic [DW-1:0]         if_data;
    logic                  if_rdy, if_rvalid;
    logic [DW-1:0]         if_rdata;
    logic [$clog2(TD):0]   pending;
    logic                  err;

    sdram_port_arbiter #(.N(N), .AW(AW), .DW(DW), .PRIO_N(PRIO_N), .TD(TD)) dut (
        .clk(clk), .n_reset(n_reset), .req(req), .we(we), .addr(addr), .data(data),
        .rdy(rdy), .rvalid(rvalid), .rdata(rdata), .if_req(if_req), .if_we(if_we),
        .if_addr(if_addr), .if_data(if_data), .if_rdy(if_rdy), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding grant at most, a queue of read tags, a rotating pointer.
    bit  m_busy;
    int  m_sel;
    int  m_rr;
    int  m_tags[$];
    bit  m_err;

    function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] w,
                                input bit full, input int rr);
        for (int i = 0; i < PRIO_N; i++)
            if (r[CW'(i)] && (w[CW'(i)] || !full)) return i;
        for (int k = 0; k < N - PRIO_N; k++) begin
            int c;
            c = PRIO_N + ((rr - PRIO_N + k) % (N - PRIO_N));
            if (r[CW'(c)] && (w[CW'(c)] || !full)) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        logic [N-1:0] e_rdy, e_rv;
        int  w;
        bit  full0;
        if (!n_reset) begin
            m_busy = 0; m_sel = 0; m_rr = PRIO_N; m_tags.delete(); m_err = 0;
            chk("rst_if_req", 64'(if_req), 64'(0));
            chk("rst_if_addr", 64'(if_addr), 64'(0));
            chk("rst_if_we", 64'(if_we), 64'(0));
            chk("rst_if_data", 64'(if_data), 64'(0));
            chk("rst_rdy", 64'(rdy), 64'(0));
            chk("rst_rvalid", 64'(rvalid), 64'(0));
            chk("rst_pending", 64'(pending), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
        end else begin
            e_rdy = (m_busy && if_rdy) ? (N'(1) << m_sel) : '0;
            e_rv  = (if_rvalid && m_tags.size() > 0) ? (N'(1) << m_tags[0]) : '0;
            chk("if_req", 64'(if_req), 64'(m_busy));
            chk("if_we", 64'(if_we), m_busy ? 64'(we[CW'(m_sel)]) : 64'(0));
            chk("if_addr", 64'(if_addr), m_busy ? 64'(addr[CW'(m_sel)]) : 64'(0));
            chk("if_data", 64'(if_data), m_busy ? 64'(data[CW'(m_sel)]) : 64'(0));
            chk("rdy", 64'(rdy), 64'(e_rdy));
            chk("rvalid", 64'(rvalid), 64'(e_rv));
            if (e_rv != 0) chk("rdata", 64'(rdata), 64'(if_rdata));
            chk("pending", 64'(pending), 64'(m_tags.size()));
            chk("err", 64'(err), 64'(m_err));
            if (m_busy) chk("proto_req_held", 64'(req[CW'(m_sel)]), 64'(1));
            // advance to the state after the coming rising edge
            full0 = (m_tags.size() == TD);
            if (if_rvalid) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (m_busy) begin
                if (if_rdy) begin
                    if (!we[CW'(m_sel)]) m_tags.push_back(m_sel);
                    m_busy = 0;
                end
            end else begin
                w = pick(req, we, full0, m_rr);
                if (w >= 0) begin
                    m_busy = 1;
                    m_sel  = w;
                    if (w >= PRIO_N) m_rr = (w + 1 >= N) ? PRIO_N : w + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input logic [N-1:0] mask, output int ch);
        ch = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((rdy & mask) != 0) begin
                for (int i = 0; i < N; i++) if (rdy[i]) ch = i;
                break;
            end
        end
        if (ch < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_rdy_timeout: got no grant, required one on mask %b", mask);
        end
    endtask

    initial begin
        int ch;
        int exp1[6];
        int exp2[4];
        exp1 = '{1, 2, 3, 1, 2, 3};
        exp2 = '{0, 1, 2, 3};
        n_reset = 0; req = '0; we = '0;
        if_rdy = 0; if_rvalid = 0; if_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'(24'h100000 * (i + 1) + 24'h00AB);
            data[i] = DW'(16'h1111 * (i + 1));
        end
        repeat (3) @(negedge clk);
        chk("lit_reset_if_req", 64'(if_req), 64'(0));
        tick(); n_reset = 1; tick();

        // 1: three round-robin writers, controller always ready
        if_rdy = 1; we = 4'b1110; req = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            wait_rdy(4'b1110, ch);
            chk($sformatf("t1_grant%0d", k), 64'(ch), 64'(exp1[k]));
        end

        // 2: fixed-priority channel jumps the queue, RR resumes from saved pointer
        tick(); req[0] = 1; we[0] = 1;
        for (int k = 0; k < 4; k++) begin
            wait_rdy(4'b1111, ch);
            chk($sformatf("t2_grant%0d", k), 64'(ch), 64'(exp2[k]));
            if (k == 0) begin tick(); req[0] = 0; end
        end
        tick(); req = '0; we = '0;
        repeat (3) tick();

        // 3: single read on ch2, data back three cycles after acceptance
        req[2] = 1;
        wait_rdy(4'b0100, ch);
        chk("t3_grant", 64'(ch), 64'(2));
        tick(); req = '0;
        @(negedge clk); chk("t3_pending1", 64'(pending), 64'(1));
        tick(); tick(); if_rvalid = 1; if_rdata = 16'hA5A5;
        @(negedge clk);
        chk("t3_rvalid", 64'(rvalid), 64'(4'b0100));
        chk("t3_rdata", 64'(rdata), 64'(16'hA5A5));
        tick(); if_rvalid = 0; if_rdata = '0;
        @(negedge clk);
        chk("t3_rvalid_off", 64'(rvalid), 64'(0));
        chk("t3_pending0", 64'(pending), 64'(0));

        // 4: fill the tag FIFO, reads stall, a write still goes through
        tick(); req = 4'b0110;
        for (int k = 0; k < 8; k++) wait_rdy(4'b0110, ch);
        repeat (10) begin
            @(negedge clk);
            chk("t4_reads_blocked", 64'(if_req), 64'(0));
        end
        chk("t4_pending_full", 64'(pending), 64'(8));
        tick(); we[3] = 1; req[3] = 1;
        wait_rdy(4'b1000, ch);
        chk("t4_write_grant", 64'(ch), 64'(3));
        tick(); req[3] = 0; we[3] = 0;
        @(negedge clk); chk("t4_pending_still8", 64'(pending), 64'(8));
        tick(); if_rvalid = 1; if_rdata = 16'h0001;
        tick(); if_rvalid = 0;
        @(negedge clk); chk("t4_pending7", 64'(pending), 64'(7));
        wait_rdy(4'b0110, ch);
        chk("t4_read_resumes", 64'(ch), 64'(1));
        tick(); req = '0;
        @(negedge clk); chk("t4_pending_refill", 64'(pending), 64'(8));
        tick(); if_rvalid = 1; if_rdata = 16'h5A5A;
        repeat (8) tick();
        if_rvalid = 0;
        @(negedge clk);
        chk("t4_drained", 64'(pending), 64'(0));
        chk("t4_err_clear", 64'(err), 64'(0));

        // 5: stray read data with nothing outstanding
        tick(); if_rvalid = 1; if_rdata = 16'hDEAD;
        @(negedge clk); chk("t5_no_rvalid", 64'(rvalid), 64'(0));
        tick(); if_rvalid = 0;
        @(negedge clk); chk("t5_err_set", 64'(err), 64'(1));
        repeat (5) tick();
        chk("t5_err_sticky", 64'(err), 64'(1));

        // 6: reset while a read is granted and three are outstanding
        req = 4'b0010;
        for (int k = 0; k < 3; k++) wait_rdy(4'b0010, ch);
        tick(); if_rdy = 0;
        ch = 0;
        for (int c = 0; c < 20 && ch == 0; c++) begin
            @(negedge clk);
            if (if_req) ch = 1;
        end
        chk("t6_granted_before_reset", 64'(ch), 64'(1));
        chk("t6_pending3", 64'(pending), 64'(3));
        #2 n_reset = 0;
        #1;
        chk("t6_rst_if_req", 64'(if_req), 64'(0));
        chk("t6_rst_pending", 64'(pending), 64'(0));
        chk("t6_rst_err", 64'(err), 64'(0));
        repeat (2) tick();
        if_rdy = 1; n_reset = 1;
        wait_rdy(4'b0010, ch);
        chk("t6_regrant", 64'(ch), 64'(1));
        tick(); req = '0;
        @(negedge clk); chk("t6_pending1", 64'(pending), 64'(1));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
